rr_rhythm_classifier: RTL and testbench
=======================================

# rr_rhythm_classifier

Beat-level back end of the Pan-Tompkins ECG chain. Consumes the QRS-detect level from the threshold stage, converts it into accepted beat events, and measures R-R intervals in sample periods. Keeps an 8-beat history and classifies the rhythm as normal, bradycardia, tachycardia or atrial fibrillation. The 2-bit rhythm code uses the LED encoding of the monitor board: 00 normal, 01 brady, 10 tachy, 11 AF.

## Interface
- CNT_W, 12, width of interval counter, rr_interval and rr_avg
- REFRACTORY, 50, samples after an accepted beat during which rising edges are ignored
- BRADY_RR, 250, rr_avg strictly above this classifies as bradycardia (250 Hz sampling, under 60 bpm)
- TACHY_RR, 150, rr_avg strictly below this classifies as tachycardia (over 100 bpm)
- AF_DEV, 40, mean absolute deviation strictly above this classifies as AF
- TIMEOUT, 1000, samples without a beat before no_beat is raised; must be less than 2^CNT_W-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_en  in  1  one-cycle strobe per ECG sample; at least 16 clk between strobes
- qrs_in  in  1  QRS-detect level from the threshold stage
- beat_pulse  out  1  one-cycle pulse per accepted beat
- rr_valid  out  1  one-cycle pulse when rr_interval is updated
- rr_interval  out  CNT_W  most recent R-R interval in samples
- rr_avg  out  CNT_W  mean of the last 8 intervals, truncated
- rhythm  out  2  rhythm class code
- rhythm_valid  out  1  level; high once 8 intervals are held and classification is complete
- no_beat  out  1  level; asystole/lead-off flag

## Operation
- qrs_in is sampled only on sample_en cycles. A rising edge is qrs_in=1 with the previous sampled value 0.
- The interval counter increments once per sample_en, saturates at 2^CNT_W-1, and clears on an accepted beat.

State machine:
- WAIT_FIRST:
  - A rising edge is accepted as a beat. It produces beat_pulse but no rr_valid.
  - The counter clears and the state moves to REFRACT.
- REFRACT:
  - Rising edges are ignored.
  - When the counter reaches REFRACTORY, the state moves to SEARCH.
- SEARCH:
  - A rising edge is accepted as a beat.
  - rr_interval is the number of samples since the previous beat (beats at sample indices i and j give j-i).
  - The interval is written into an 8-entry circular buffer and the running sum is updated: sum += new - evicted.
  - fill increments and saturates at 8.
  - The state moves to CALC.
- CALC:
  - rr_avg = sum>>3.
  - The block then iterates over the 8 entries, one per clk, accumulating |rr_k - rr_avg| into dev_sum (CNT_W+3 bits, unsigned).
  - When done, the state moves to REFRACT (or SEARCH if the counter is already at or above REFRACTORY).
  - Counting and timeout continue during CALC.
- Classification runs at the end of CALC, only when fill==8, with this priority:
  1. (dev_sum>>3) > AF_DEV gives 11.
  2. Otherwise rr_avg > BRADY_RR gives 01.
  3. Otherwise rr_avg < TACHY_RR gives 10.
  4. Otherwise 00.
  - If fill<8, rhythm holds and rhythm_valid stays 0.
- Timeout:
  - In REFRACT, SEARCH or CALC, if the counter reaches TIMEOUT, no_beat is set, fill, sum and the buffer clear, rhythm_valid clears, and the state moves to WAIT_FIRST.
  - no_beat clears on the next accepted beat.
  - Timeout has priority over a rising edge on the same sample.
- The sum is CNT_W+3 bits and never overflows.
- All subtractions are widened; absolute deviation is non-negative.

## Timing
- Reset: every output is 0, buffer, sum, fill and counter are 0, and the state is WAIT_FIRST.
  - A reset asserted mid-CALC aborts the CALC; no partial result is published.
- Beat accepted on the sample_en cycle T:
  - beat_pulse and rr_valid go high in cycle T+1 for exactly one clk.
  - rr_interval is valid from T+1 and held until the next beat.
- rr_avg updates at T+2.
- The deviation loop runs T+2..T+9. rhythm and rhythm_valid update at T+10.
- Outputs are held between updates.
- Under the 16-clk sample_en spacing rule, no beat can arrive during CALC.

## Test plan
- Reset: assert rst for 2 clk mid-stream → all outputs 0 on the next clk; the first following beat gives beat_pulse only, no rr_valid.
- Regular rhythm: rising edges every 200 samples, 9 beats → eight rr_valid pulses with rr_interval=200, rr_avg=200, rhythm=00, rhythm_valid=1 at T+10 after the 9th beat and 0 before it.
- Rate extremes: intervals of 300 → rhythm=01; intervals of 120 → rhythm=10; an interval of exactly 250 or 150 → rhythm=00.
- AF: intervals alternating 100 and 220 → rr_avg=160, dev_sum>>3=60 → rhythm=11. Alternating 150 and 170 (deviation 10) → rhythm=00.
- Refractory and level handling: qrs_in held high for 30 samples gives one beat; a second rising edge 20 samples after a beat is ignored, so the next RR is measured from the original beat.
- Timeout: stop beats after a valid classification → at 1000 samples no_beat=1 and rhythm_valid=0. On resume, the first beat clears no_beat with no rr_valid, and 8 further intervals are needed before rhythm_valid=1.

Source files
------------

// File: rtl/rr_rhythm_classifier.sv
// Beat-level back end of the Pan-Tompkins chain: QRS edge -> accepted beat, R-R interval,
// 8-beat history and rhythm class (00 normal, 01 brady, 10 tachy, 11 AF).
module rr_rhythm_classifier #(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned REFRACTORY = 50,
    parameter int unsigned BRADY_RR   = 250,
    parameter int unsigned TACHY_RR   = 150,
    parameter int unsigned AF_DEV     = 40,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             qrs_in,
    output logic             beat_pulse,
    output logic             rr_valid,
    output logic [CNT_W-1:0] rr_interval,
    output logic [CNT_W-1:0] rr_avg,
    output logic [1:0]       rhythm,
    output logic             rhythm_valid,
    output logic             no_beat
);
    localparam int unsigned SUM_W = CNT_W + 3;

    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] RefrCnt    = CNT_W'(REFRACTORY);
    localparam logic [CNT_W-1:0] BradyCnt   = CNT_W'(BRADY_RR);
    localparam logic [CNT_W-1:0] TachyCnt   = CNT_W'(TACHY_RR);
    localparam logic [CNT_W-1:0] AfCnt      = CNT_W'(AF_DEV);
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StWaitFirst, StRefract, StSearch, StCalc} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             qrs_prev_q;
    logic [CNT_W-1:0] rr_buf_q [8];
    logic [2:0]       wr_ptr_q;
    logic [SUM_W-1:0] sum_q;
    logic [3:0]       fill_q;
    logic [SUM_W-1:0] dev_sum_q;
    logic             calc_first_q;
    logic [2:0]       calc_idx_q;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_now;
    logic [CNT_W-1:0] calc_entry;
    logic [CNT_W-1:0] abs_dev;
    logic [SUM_W-1:0] sum_upd;
    logic [SUM_W-1:0] dev_next;
    logic             rise;
    logic             timeout_hit;

    always_comb begin
        cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_now     = sample_en ? cnt_inc : cnt_q;
        rise        = sample_en && qrs_in && !qrs_prev_q;
        timeout_hit = sample_en && (state_q != StWaitFirst) && (cnt_inc >= TimeoutCnt);
        // Final sum always fits in SUM_W, so modular add/subtract is exact.
        sum_upd     = sum_q + SUM_W'(cnt_inc) - SUM_W'(rr_buf_q[wr_ptr_q]);
        calc_entry  = rr_buf_q[calc_idx_q];
        abs_dev     = (calc_entry >= rr_avg) ? calc_entry - rr_avg : rr_avg - calc_entry;
        dev_next    = dev_sum_q + SUM_W'(abs_dev);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StWaitFirst;
            cnt_q        <= '0;
            qrs_prev_q   <= 1'b0;
            wr_ptr_q     <= '0;
            sum_q        <= '0;
            fill_q       <= '0;
            dev_sum_q    <= '0;
            calc_first_q <= 1'b0;
            calc_idx_q   <= '0;
            for (int i = 0; i < 8; i++) rr_buf_q[i] <= '0;
            beat_pulse   <= 1'b0;
            rr_valid     <= 1'b0;
            rr_interval  <= '0;
            rr_avg       <= '0;
            rhythm       <= 2'b00;
            rhythm_valid <= 1'b0;
            no_beat      <= 1'b0;
        end else begin
            beat_pulse <= 1'b0;
            rr_valid   <= 1'b0;
            if (sample_en) begin
                qrs_prev_q <= qrs_in;
                cnt_q      <= cnt_inc;
            end

            if (timeout_hit) begin
                // Asystole / lead-off: drop the history and wait for a fresh first beat.
                no_beat      <= 1'b1;
                rhythm_valid <= 1'b0;
                fill_q       <= '0;
                sum_q        <= '0;
                wr_ptr_q     <= '0;
                calc_first_q <= 1'b0;
                calc_idx_q   <= '0;
                for (int i = 0; i < 8; i++) rr_buf_q[i] <= '0;
                state_q      <= StWaitFirst;
            end else begin
                unique case (state_q)
                    StWaitFirst: begin
                        if (rise) begin
                            beat_pulse <= 1'b1;
                            no_beat    <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= StRefract;
                        end
                    end
                    StRefract: begin
                        if (sample_en && (cnt_inc >= RefrCnt)) state_q <= StSearch;
                    end
                    StSearch: begin
                        if (rise) begin
                            beat_pulse         <= 1'b1;
                            rr_valid           <= 1'b1;
                            no_beat            <= 1'b0;
                            rr_interval        <= cnt_inc;
                            rr_buf_q[wr_ptr_q] <= cnt_inc;
                            wr_ptr_q           <= wr_ptr_q + 3'd1;
                            sum_q              <= sum_upd;
                            if (fill_q != 4'd8) fill_q <= fill_q + 4'd1;
                            cnt_q              <= '0;
                            calc_first_q       <= 1'b1;
                            calc_idx_q         <= '0;
                            state_q            <= StCalc;
                        end
                    end
                    StCalc: begin
                        if (calc_first_q) begin
                            rr_avg       <= sum_q[SUM_W-1:3];
                            dev_sum_q    <= '0;
                            calc_first_q <= 1'b0;
                        end else begin
                            dev_sum_q  <= dev_next;
                            calc_idx_q <= calc_idx_q + 3'd1;
                            if (calc_idx_q == 3'd7) begin
                                if (fill_q == 4'd8) begin
                                    rhythm_valid <= 1'b1;
                                    if (dev_next[SUM_W-1:3] > AfCnt) begin
                                        rhythm <= 2'b11;
                                    end else if (rr_avg > BradyCnt) begin
                                        rhythm <= 2'b01;
                                    end else if (rr_avg < TachyCnt) begin
                                        rhythm <= 2'b10;
                                    end else begin
                                        rhythm <= 2'b00;
                                    end
                                end
                                state_q <= (cnt_now >= RefrCnt) ? StSearch : StRefract;
                            end
                        end
                    end
                    default: state_q <= StWaitFirst;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rr_rhythm_classifier.sv
// Directed bench: three DUT lanes share one sample strobe and run independent segment
// tables in parallel; each accepted beat is checked at T+1, T+2, T+9 and T+10.
module tb_rr_rhythm_classifier;
    localparam int CNT_W = 12;
    localparam int NL    = 3;
    localparam int NSEG  = 15;

    typedef struct {
        int lane;
        int act;        // 0 none, 1 mid-stream reset first, 2 let it time out first
        int iv_a;
        int iv_b;       // intervals alternate iv_a, iv_b, iv_a, ...
        int beats;
        int hold;       // samples qrs stays high counting the beat sample
        int glitch;     // extra 2-sample rising edge at this offset (0 = none)
        int exp_avg;
        int exp_rhythm;
        int exp_valid;
    } seg_t;

    logic             clk = 1'b0;
    logic             sample_en;
    logic [NL-1:0]    rst;
    logic [NL-1:0]    qrs;
    logic [NL-1:0]    beat_pulse;
    logic [NL-1:0]    rr_valid;
    logic [NL-1:0]    rhythm_valid;
    logic [NL-1:0]    no_beat;
    logic [CNT_W-1:0] rr_interval [NL];
    logic [CNT_W-1:0] rr_avg      [NL];
    logic [1:0]       rhythm      [NL];

    seg_t tbl [NSEG];
    int   n_checks = 0;
    int   n_errors = 0;
    int   bp_cnt   [NL];
    bit   lane_first [NL];
    int   lane_fill  [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        rr_rhythm_classifier u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .sample_en    (sample_en),
            .qrs_in       (qrs[g]),
            .beat_pulse   (beat_pulse[g]),
            .rr_valid     (rr_valid[g]),
            .rr_interval  (rr_interval[g]),
            .rr_avg       (rr_avg[g]),
            .rhythm       (rhythm[g]),
            .rhythm_valid (rhythm_valid[g]),
            .no_beat      (no_beat[g])
        );
    end

    initial forever #5 clk = ~clk;

    initial begin
        sample_en = 1'b0;
        forever begin
            repeat (15) @(negedge clk);
            sample_en = 1'b1;
            @(negedge clk);
            sample_en = 1'b0;
        end
    end

    initial begin
        for (int i = 0; i < NL; i++) bp_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) if (beat_pulse[i] === 1'b1) bp_cnt[i] <= bp_cnt[i] + 1;
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation still running at t=%0t, limit 1200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input int lane, input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL lane%0d %s: got %0d expected %0d (t=%0t)", lane, name, act, exp, $time);
        end
    endtask

    task automatic wait_sample();
        do @(posedge clk); while (sample_en !== 1'b1);
    endtask

    task automatic check_idle(input int lane);
        chk(lane, "idle beat_pulse", beat_pulse[lane], 0);
        chk(lane, "idle rr_valid", rr_valid[lane], 0);
        chk(lane, "idle rr_interval", rr_interval[lane], 0);
        chk(lane, "idle rr_avg", rr_avg[lane], 0);
        chk(lane, "idle rhythm", rhythm[lane], 0);
        chk(lane, "idle rhythm_valid", rhythm_valid[lane], 0);
        chk(lane, "idle no_beat", no_beat[lane], 0);
    endtask

    // Drive one beat iv samples after the previous one and check the beat timeline.
    task automatic do_beat(input int lane, input int iv, input int hold, input int glitch,
                           output int avg_o, output int rhy_o);
        int bp0;
        bit was_first;
        bit rv_old;
        bp0       = bp_cnt[lane];
        was_first = lane_first[lane];
        rv_old    = (lane_fill[lane] == 8);
        for (int k = 1; k <= iv; k++) begin
            @(negedge clk);
            qrs[lane] = (k < hold) || (glitch > 0 && k >= glitch && k < glitch + 2) || (k == iv);
            wait_sample();
        end
        if (!was_first && lane_fill[lane] < 8) lane_fill[lane]++;
        lane_first[lane] = 1'b0;
        @(negedge clk);
        chk(lane, "beat_pulse@T+1", beat_pulse[lane], 1);
        chk(lane, "rr_valid@T+1", rr_valid[lane], was_first ? 0 : 1);
        if (!was_first) chk(lane, "rr_interval", rr_interval[lane], iv);
        chk(lane, "no_beat@beat", no_beat[lane], 0);
        @(negedge clk);
        chk(lane, "beat_pulse@T+2", beat_pulse[lane], 0);
        chk(lane, "rr_valid@T+2", rr_valid[lane], 0);
        chk(lane, "beats_accepted", bp_cnt[lane] - bp0, 1);
        avg_o = rr_avg[lane];
        repeat (7) @(negedge clk);
        chk(lane, "rhythm_valid@T+9", rhythm_valid[lane], rv_old);
        @(negedge clk);
        chk(lane, "rhythm_valid@T+10", rhythm_valid[lane], (lane_fill[lane] == 8) ? 1 : 0);
        rhy_o = rhythm[lane];
    endtask

    task automatic do_reset(input int lane);
        @(negedge clk);
        qrs[lane] = 1'b0;
        rst[lane] = 1'b1;
        repeat (2) @(negedge clk);
        rst[lane] = 1'b0;
        check_idle(lane);
        lane_first[lane] = 1'b1;
        lane_fill[lane]  = 0;
    endtask

    // Called right after a beat: no further edges, so TIMEOUT samples later no_beat rises.
    task automatic do_timeout(input int lane);
        for (int k = 1; k < 1000; k++) begin
            @(negedge clk);
            qrs[lane] = (k < 3);
            wait_sample();
        end
        @(negedge clk);
        chk(lane, "no_beat@999", no_beat[lane], 0);
        chk(lane, "rhythm_valid@999", rhythm_valid[lane], (lane_fill[lane] == 8) ? 1 : 0);
        wait_sample();
        @(negedge clk);
        chk(lane, "no_beat@1000", no_beat[lane], 1);
        chk(lane, "rhythm_valid@1000", rhythm_valid[lane], 0);
        lane_first[lane] = 1'b1;
        lane_fill[lane]  = 0;
    endtask

    task automatic run_lane(input int lane);
        int avg;
        int rhy;
        avg = 0;
        rhy = 0;
        check_idle(lane);
        for (int i = 0; i < NSEG; i++) begin
            if (tbl[i].lane == lane) begin
                if (tbl[i].act == 1) do_reset(lane);
                if (tbl[i].act == 2) do_timeout(lane);
                for (int b = 0; b < tbl[i].beats; b++) begin
                    do_beat(lane, (b % 2 == 0) ? tbl[i].iv_a : tbl[i].iv_b, tbl[i].hold,
                            tbl[i].glitch, avg, rhy);
                end
                chk(lane, $sformatf("seg%0d rr_avg", i), avg, tbl[i].exp_avg);
                chk(lane, $sformatf("seg%0d rhythm", i), rhy, tbl[i].exp_rhythm);
                chk(lane, $sformatf("seg%0d rhythm_valid", i), rhythm_valid[lane],
                    tbl[i].exp_valid);
            end
        end
    endtask

    initial begin
        //            lane act iv_a iv_b beats hold glitch avg rhy valid
        tbl[0]  = '{0, 0,  10,  10, 1,  1,  0,   0, 0, 0};  // first beat only
        tbl[1]  = '{0, 0, 200, 200, 1, 30, 40,  25, 0, 0};  // long level + edge in refractory
        tbl[2]  = '{0, 1,  10,  10, 1,  1,  0,   0, 0, 0};  // reset, then first beat again
        tbl[3]  = '{0, 0, 200, 200, 1, 30,  0,  25, 0, 0};
        tbl[4]  = '{0, 0, 200, 200, 7,  3, 20, 200, 0, 1};  // 9th beat -> normal
        tbl[5]  = '{0, 0, 100, 220, 8,  3,  0, 160, 3, 1};  // AF, deviation 60
        tbl[6]  = '{0, 0, 150, 170, 8,  3,  0, 160, 0, 1};  // deviation 10 -> normal
        tbl[7]  = '{1, 0,  10,  10, 1,  1,  0,   0, 0, 0};
        tbl[8]  = '{1, 0, 300, 300, 8,  3,  0, 300, 1, 1};  // brady
        tbl[9]  = '{1, 0, 250, 250, 8,  3,  0, 250, 0, 1};  // exactly BRADY_RR -> normal
        tbl[10] = '{2, 0,  10,  10, 1,  1,  0,   0, 0, 0};
        tbl[11] = '{2, 0, 120, 120, 8,  3,  0, 120, 2, 1};  // tachy
        tbl[12] = '{2, 0, 150, 150, 8,  3,  0, 150, 0, 1};  // exactly TACHY_RR -> normal
        tbl[13] = '{2, 2,  10,  10, 1,  1,  0, 150, 0, 0};  // timeout, resume
        tbl[14] = '{2, 0, 120, 120, 8,  3,  0, 120, 2, 1};  // history rebuilt

        rst = '1;
        qrs = '0;
        for (int i = 0; i < NL; i++) begin
            lane_first[i] = 1'b1;
            lane_fill[i]  = 0;
        end
        repeat (3) @(negedge clk);
        rst = '0;
        @(negedge clk);
        fork
            run_lane(0);
            run_lane(1);
            run_lane(2);
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
